// File: rtl/bitty_pkg.sv
// bitty_pkg: shared types, ALU select codes and field helpers
// for the bitty_core_p execution core.
package bitty_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXEC,
    WB
  } state_e;

  // Logical select codes (mode = 1)
  localparam logic [3:0] L_NA   = 4'h0;
  localparam logic [3:0] L_NOR  = 4'h1;
  localparam logic [3:0] L_NAB  = 4'h2;
  localparam logic [3:0] L_ZERO = 4'h3;
  localparam logic [3:0] L_NAND = 4'h4;
  localparam logic [3:0] L_NB   = 4'h5;
  localparam logic [3:0] L_XOR  = 4'h6;
  localparam logic [3:0] L_ANB  = 4'h7;
  localparam logic [3:0] L_NAOB = 4'h8;
  localparam logic [3:0] L_XNOR = 4'h9;
  localparam logic [3:0] L_B    = 4'hA;
  localparam logic [3:0] L_AND  = 4'hB;
  localparam logic [3:0] L_ONES = 4'hC;
  localparam logic [3:0] L_AONB = 4'hD;
  localparam logic [3:0] L_OR   = 4'hE;
  localparam logic [3:0] L_A    = 4'hF;

  // Arithmetic select codes (mode = 0)
  localparam logic [3:0] A_A     = 4'h0;
  localparam logic [3:0] A_OR    = 4'h1;
  localparam logic [3:0] A_ORN   = 4'h2;
  localparam logic [3:0] A_ONES  = 4'h3;
  localparam logic [3:0] A_APANB = 4'h4;
  localparam logic [3:0] A_OPANB = 4'h5;
  localparam logic [3:0] A_SUBM1 = 4'h6;
  localparam logic [3:0] A_ANBM1 = 4'h7;
  localparam logic [3:0] A_APAB  = 4'h8;
  localparam logic [3:0] A_ADD   = 4'h9;
  localparam logic [3:0] A_ONPAB = 4'hA;
  localparam logic [3:0] A_ABM1  = 4'hB;
  localparam logic [3:0] A_DBL   = 4'hC;
  localparam logic [3:0] A_ORPA  = 4'hD;
  localparam logic [3:0] A_ONPA  = 4'hE;
  localparam logic [3:0] A_DEC   = 4'hF;

  // rx occupies the top REG_AW bits of the instruction
  function automatic int rx_lo(input int aw);
    return aw + 10;
  endfunction

  // ry sits directly below rx
  function automatic int ry_lo(input int aw);
    return rx_lo(aw) - aw;
  endfunction

endpackage

// File: rtl/bitty_alu_p.sv
// bitty_alu_p: 74181-style combinational ALU, 16 logical and
// 16 arithmetic functions, carry/borrow and equality outputs.
module bitty_alu_p
  import bitty_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [3:0]        sel_i,
  input  logic              mode_i,
  output logic [DATA_W-1:0] res_o,
  output logic              carry_o,
  output logic              equal_o
);

  logic [DATA_W:0]   a, b, one, ones;
  logic [DATA_W:0]   anb, ab, aob, aonb;
  logic [DATA_W:0]   ari;
  logic [DATA_W-1:0] lgc;

  assign a    = {1'b0, a_i};
  assign b    = {1'b0, b_i};
  assign one  = {{DATA_W{1'b0}}, 1'b1};
  assign ones = {1'b0, {DATA_W{1'b1}}};
  assign anb  = {1'b0, a_i & ~b_i};
  assign ab   = {1'b0, a_i & b_i};
  assign aob  = {1'b0, a_i | b_i};
  assign aonb = {1'b0, a_i | ~b_i};

  // Logical function table
  always_comb begin
    lgc = '0;
    unique case (sel_i)
      L_NA:    lgc = ~a_i;
      L_NOR:   lgc = ~(a_i | b_i);
      L_NAB:   lgc = ~a_i & b_i;
      L_ZERO:  lgc = '0;
      L_NAND:  lgc = ~(a_i & b_i);
      L_NB:    lgc = ~b_i;
      L_XOR:   lgc = a_i ^ b_i;
      L_ANB:   lgc = a_i & ~b_i;
      L_NAOB:  lgc = ~a_i | b_i;
      L_XNOR:  lgc = ~(a_i ^ b_i);
      L_B:     lgc = b_i;
      L_AND:   lgc = a_i & b_i;
      L_ONES:  lgc = '1;
      L_AONB:  lgc = a_i | ~b_i;
      L_OR:    lgc = a_i | b_i;
      L_A:     lgc = a_i;
      default: lgc = '0;
    endcase
  end

  // Arithmetic table on zero-extended operands; MSB is carry/borrow
  always_comb begin
    ari = '0;
    unique case (sel_i)
      A_A:     ari = a;
      A_OR:    ari = aob;
      A_ORN:   ari = aonb;
      A_ONES:  ari = ones;
      A_APANB: ari = a + anb;
      A_OPANB: ari = aob + anb;
      A_SUBM1: ari = a - b - one;
      A_ANBM1: ari = anb - one;
      A_APAB:  ari = a + ab;
      A_ADD:   ari = a + b;
      A_ONPAB: ari = aonb + ab;
      A_ABM1:  ari = ab - one;
      A_DBL:   ari = a + a;
      A_ORPA:  ari = aob + a;
      A_ONPA:  ari = aonb + a;
      A_DEC:   ari = a - one;
      default: ari = '0;
    endcase
  end

  assign res_o   = mode_i ? lgc : ari[DATA_W-1:0];
  assign carry_o = ~mode_i & ari[DATA_W];
  assign equal_o = (a_i == b_i);

endmodule

// File: rtl/bitty_core_p.sv
// bitty_core_p: 4-clock bitty execution core with run/done handshake.
// Define BITTY_FLAGS_EN to add registered carry_flag/equal_flag.
module bitty_core_p
  import bitty_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [2*REG_AW+9:0]   instruction,
  output logic                  busy,
  output logic                  done,
  input  logic [REG_AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
`ifdef BITTY_FLAGS_EN
  ,
  output logic                  carry_flag,
  output logic                  equal_flag
`endif
);

  localparam int NUM_REGS = 2**REG_AW;
  localparam int RX_LO    = rx_lo(REG_AW);
  localparam int RY_LO    = ry_lo(REG_AW);

  state_e state_q, state_d;

  logic [REG_AW-1:0] rx_q, ry_q;
  logic [3:0]        sel_q;
  logic              mode_q;
  logic [DATA_W-1:0] s_q, c_q;
  logic              done_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] alu_res;

  logic unused_instr;
  assign unused_instr = ^{instruction[RY_LO-1:7],
                          instruction[1:0]};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and busy decode
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    unique case (state_q)
      IDLE: if (run) state_d = LOAD;
      LOAD: begin
        busy    = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        busy    = 1'b1;
        state_d = WB;
      end
      WB: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // IR capture, operand/result latches and done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_q   <= '0;
      ry_q   <= '0;
      sel_q  <= '0;
      mode_q <= 1'b0;
      s_q    <= '0;
      c_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == WB);
      if (state_q == IDLE && run) begin
        rx_q   <= instruction[RX_LO +: REG_AW];
        ry_q   <= instruction[RY_LO +: REG_AW];
        sel_q  <= instruction[6:3];
        mode_q <= instruction[2];
      end
      if (state_q == LOAD) s_q <= regs_q[rx_q];
      if (state_q == EXEC) c_q <= alu_res;
    end
  end

  // Register file, written back in WB
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else if (state_q == WB) begin
      regs_q[rx_q] <= c_q;
    end
  end

`ifdef BITTY_FLAGS_EN
  logic alu_carry, alu_equal;
  logic carry_q, equal_q;

  bitty_alu_p #(.DATA_W(DATA_W)) u_alu (
    .a_i     (s_q),
    .b_i     (regs_q[ry_q]),
    .sel_i   (sel_q),
    .mode_i  (mode_q),
    .res_o   (alu_res),
    .carry_o (alu_carry),
    .equal_o (alu_equal)
  );

  // Flags update with the result, hold until next EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_q <= 1'b0;
      equal_q <= 1'b0;
    end else if (state_q == EXEC) begin
      carry_q <= alu_carry;
      equal_q <= alu_equal;
    end
  end

  assign carry_flag = carry_q;
  assign equal_flag = equal_q;
`else
  bitty_alu_p #(.DATA_W(DATA_W)) u_alu (
    .a_i     (s_q),
    .b_i     (regs_q[ry_q]),
    .sel_i   (sel_q),
    .mode_i  (mode_q),
    .res_o   (alu_res),
    .carry_o (),
    .equal_o ()
  );
`endif

  assign done     = done_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_bitty_core_p.sv
// tb_bitty_core_p: directed and random stimulus for bitty_core_p
// checked cycle by cycle against a behavioural model.
module tb_bitty_core_p;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] instruction;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
`ifdef BITTY_FLAGS_EN
  logic        carry_flag;
  logic        equal_flag;
`endif

  always #5 clk = ~clk;

  bitty_core_p #(.DATA_W(16), .REG_AW(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .instruction (instruction),
    .busy        (busy),
    .done        (done),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
`ifdef BITTY_FLAGS_EN
    ,
    .carry_flag  (carry_flag),
    .equal_flag  (equal_flag)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] mreg [8];
  logic        mcarry, mequal;
  logic        pcarry, pequal;
  logic [15:0] pres;
  logic [2:0]  prx;
  bit          pend;
  int          cyc, acc, wb_cyc, next_ok, done_cyc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // {carry, result} straight from the function tables
  function automatic logic [16:0] ref_alu(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [3:0] s,
                                          input logic m);
    int unsigned A  = {16'h0, a};
    int unsigned B  = {16'h0, b};
    int unsigned NB = {16'h0, ~b};
    int unsigned t  = 0;
    if (m) begin
      case (s)
        4'h0: t = ~A;
        4'h1: t = ~(A | B);
        4'h2: t = ~A & B;
        4'h3: t = 0;
        4'h4: t = ~(A & B);
        4'h5: t = ~B;
        4'h6: t = A ^ B;
        4'h7: t = A & NB;
        4'h8: t = ~A | B;
        4'h9: t = ~(A ^ B);
        4'hA: t = B;
        4'hB: t = A & B;
        4'hC: t = 32'hFFFF;
        4'hD: t = A | NB;
        4'hE: t = A | B;
        default: t = A;
      endcase
      return {1'b0, t[15:0]};
    end
    case (s)
      4'h0: t = A;
      4'h1: t = A | B;
      4'h2: t = A | NB;
      4'h3: t = 32'hFFFF;
      4'h4: t = A + (A & NB);
      4'h5: t = (A | B) + (A & NB);
      4'h6: t = A - B - 1;
      4'h7: t = (A & NB) - 1;
      4'h8: t = A + (A & B);
      4'h9: t = A + B;
      4'hA: t = (A | NB) + (A & B);
      4'hB: t = (A & B) - 1;
      4'hC: t = A + A;
      4'hD: t = (A | B) + A;
      4'hE: t = (A | NB) + A;
      default: t = A - 1;
    endcase
    return {(s > 4'h3) ? t[16] : 1'b0, t[15:0]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    mcarry   = 1'b0;
    mequal   = 1'b0;
    pend     = 1'b0;
    next_ok  = 0;
    done_cyc = -1;
    wb_cyc   = -1;
    acc      = -1;
  endtask

  // One clock: drive at negedge, advance model at posedge, check at negedge
  task automatic step(input logic r, input logic [15:0] ins);
    logic [16:0] res;
    run         = r;
    instruction = ins;
    dbg_addr    = 3'($urandom);
    @(posedge clk);
    cyc++;
    if (pend && cyc == acc + 2) begin
      mcarry = pcarry;
      mequal = pequal;
    end
    if (pend && cyc == wb_cyc) begin
      mreg[prx] = pres;
      pend      = 1'b0;
      done_cyc  = cyc;
    end
    if (!pend && r && cyc >= next_ok) begin
      res     = ref_alu(mreg[ins[15:13]], mreg[ins[12:10]],
                        ins[6:3], ins[2]);
      pres    = res[15:0];
      pcarry  = res[16];
      pequal  = (mreg[ins[15:13]] == mreg[ins[12:10]]);
      prx     = ins[15:13];
      pend    = 1'b1;
      acc     = cyc;
      wb_cyc  = cyc + 3;
      next_ok = cyc + 4;
    end
    @(negedge clk);
    chk("busy", busy, pend);
    chk("done", done, cyc == done_cyc);
    chk("dbg", dbg_data, mreg[dbg_addr]);
`ifdef BITTY_FLAGS_EN
    chk("carry", carry_flag, mcarry);
    chk("equal", equal_flag, mequal);
`endif
  endtask

  task automatic peek(input string tag, input logic [2:0] a,
                      input logic [15:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic issue(input logic [15:0] ins);
    step(1'b1, ins);
    repeat (4) step(1'b0, 16'($urandom));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    #1;
    model_clear();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef BITTY_FLAGS_EN
    chk("rst_carry", carry_flag, 0);
    chk("rst_equal", equal_flag, 0);
`endif
    for (int i = 0; i < 8; i++) peek("rst_reg", 3'(i), 16'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    run         = 1'b0;
    instruction = '0;
    dbg_addr    = '0;
    cyc         = 0;
    model_clear();
    @(negedge clk);
    do_reset();

    issue(16'h2064);
    peek("r1_ones", 3'd1, 16'hFFFF);

    issue(16'h4078);
    peek("r2_dec", 3'd2, 16'hFFFF);
`ifdef BITTY_FLAGS_EN
    chk("r2_borrow", carry_flag, 1);
`endif

    issue(16'h2848);
    peek("r1_add", 3'd1, 16'hFFFE);
`ifdef BITTY_FLAGS_EN
    chk("r1_carry", carry_flag, 1);
`endif

    issue(16'h2434);
    peek("r1_xor", 3'd1, 16'h0000);
`ifdef BITTY_FLAGS_EN
    chk("r1_equal", equal_flag, 1);
`endif

    // run toggled with another instruction while busy
    step(1'b1, 16'h2064);
    step(1'b0, 16'h6064);
    step(1'b1, 16'h6064);
    step(1'b1, 16'h6064);
    peek("r3_ignored", 3'd3, 16'h0000);
    peek("r1_first", 3'd1, 16'hFFFF);
    step(1'b1, 16'h6064);
    chk("accept_n4", busy, 1);
    repeat (4) step(1'b0, 16'h0);
    peek("r3_second", 3'd3, 16'hFFFF);

    // reset while in EXEC aborts the writeback
    issue(16'h2434);
    step(1'b1, 16'h2064);
    step(1'b0, 16'h0);
    do_reset();
    peek("abort_r1", 3'd1, 16'h0000);
    step(1'b1, 16'h2064);
    chk("post_rst_acc", busy, 1);
    repeat (4) step(1'b0, 16'h0);
    peek("post_rst_r1", 3'd1, 16'hFFFF);

    repeat (400) step($urandom_range(0, 3) != 0, 16'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
